// File: rtl/anti_theft_fsm.sv
// anti_theft_fsm: vehicle anti-theft controller.
// Arms itself after the driver leaves and the arming delay runs out. An
// opened door while armed starts the entry countdown, and the siren sounds
// if the ignition is not turned on in time. The alarm re-arms after the
// doors have stayed closed for the alarm interval. The fuel pump is enabled
// only by the hidden-switch + brake + ignition combination.
//
// Optional feature macro: STATUS_BLINK_EN
//   defined   -> in ARMED the status LED toggles on every one_hz_enable pulse,
//                and the blink phase restarts at 0 on each entry to ARMED.
//   undefined -> the status LED is steady on in ARMED; one_hz_enable unused.
module anti_theft_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_passenger,
    input  logic       hidden,
    input  logic       brake,
    input  logic       reprogram,
    input  logic       expired,
    input  logic       one_hz_enable,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       siren,
    output logic       status_indicator,
    output logic       fuel_pump,
    output logic [2:0] state_code
);

    typedef enum logic [2:0] {
        ARMED           = 3'd0,
        TRIGGERED       = 3'd1,
        SOUND_ALARM     = 3'd2,
        DISARMED        = 3'd3,
        WAIT_DOOR_OPEN  = 3'd4,
        WAIT_DOOR_CLOSE = 3'd5,
        ARM_DELAY       = 3'd6
    } state_t;

    localparam logic [1:0] T_ARM_DELAY       = 2'b00;
    localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
    localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
    localparam logic [1:0] T_ALARM_ON        = 2'b11;

    // True when either door is open.
    function automatic logic any_door_open(input logic drv, input logic pas);
        return drv | pas;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       start_timer_r;
    logic       start_timer_next_s;
    logic [1:0] interval_r;
    logic [1:0] interval_next_s;
    logic       siren_r;
    logic       siren_next_s;
    logic       status_r;
    logic       status_next_s;
    logic       fuel_pump_r;
    logic       fuel_pump_next_s;
    logic       reprogram_prev_r;
    logic       reprogram_edge_s;
    // In SOUND_ALARM: countdown must be (re)started at the next closed-door cycle.
    logic       restart_pend_r;
    logic       restart_pend_next_s;
    // In SOUND_ALARM: the alarm-on countdown is running and expiry is valid.
    logic       alarm_run_r;
    logic       alarm_run_next_s;
    logic       doors_open_s;
    // Expiry is never honoured in the cycle the timer is being (re)loaded.
    logic       expired_ok_s;
    logic       armed_status_s;

`ifdef STATUS_BLINK_EN
    logic       blink_phase_r;
    logic       blink_phase_next_s;
`else
    logic       unused_one_hz_s;
`endif

    assign reprogram_edge_s = reprogram & ~reprogram_prev_r;
    assign doors_open_s     = any_door_open(door_driver, door_passenger);
    assign expired_ok_s     = expired & ~start_timer_r;

    // Next-state and timer-start decision; priority reprogram > ignition > FSM.
    always_comb begin
        state_next_s        = state_r;
        start_timer_next_s  = 1'b0;
        interval_next_s     = interval_r;
        restart_pend_next_s = restart_pend_r;
        alarm_run_next_s    = alarm_run_r;

        if (reprogram_edge_s) begin
            state_next_s = ARMED;
        end else if (ignition) begin
            state_next_s = DISARMED;
        end else begin
            case (state_r)
                ARMED: begin
                    if (door_driver) begin
                        state_next_s       = TRIGGERED;
                        start_timer_next_s = 1'b1;
                        interval_next_s    = T_DRIVER_DELAY;
                    end else if (door_passenger) begin
                        state_next_s       = TRIGGERED;
                        start_timer_next_s = 1'b1;
                        interval_next_s    = T_PASSENGER_DELAY;
                    end else begin
                        state_next_s = ARMED;
                    end
                end
                TRIGGERED: begin
                    if (expired_ok_s) begin
                        state_next_s        = SOUND_ALARM;
                        restart_pend_next_s = 1'b1;
                        alarm_run_next_s    = 1'b0;
                    end else begin
                        state_next_s = TRIGGERED;
                    end
                end
                SOUND_ALARM: begin
                    if (doors_open_s) begin
                        // Open door aborts the countdown; restart once closed.
                        restart_pend_next_s = 1'b1;
                        alarm_run_next_s    = 1'b0;
                    end else if (restart_pend_r && !start_timer_r) begin
                        start_timer_next_s  = 1'b1;
                        interval_next_s     = T_ALARM_ON;
                        restart_pend_next_s = 1'b0;
                        alarm_run_next_s    = 1'b1;
                    end else if (expired_ok_s && alarm_run_r) begin
                        state_next_s = ARMED;
                    end else begin
                        state_next_s = SOUND_ALARM;
                    end
                end
                DISARMED: begin
                    if (!ignition) begin
                        state_next_s = WAIT_DOOR_OPEN;
                    end else begin
                        state_next_s = DISARMED;
                    end
                end
                WAIT_DOOR_OPEN: begin
                    if (door_driver) begin
                        state_next_s = WAIT_DOOR_CLOSE;
                    end else begin
                        state_next_s = WAIT_DOOR_OPEN;
                    end
                end
                WAIT_DOOR_CLOSE: begin
                    // Both doors must be shut, otherwise an open passenger door
                    // would bounce between here and ARM_DELAY every cycle.
                    if (!doors_open_s) begin
                        state_next_s       = ARM_DELAY;
                        start_timer_next_s = 1'b1;
                        interval_next_s    = T_ARM_DELAY;
                    end else begin
                        state_next_s = WAIT_DOOR_CLOSE;
                    end
                end
                ARM_DELAY: begin
                    if (doors_open_s) begin
                        state_next_s = WAIT_DOOR_CLOSE;
                    end else if (expired_ok_s) begin
                        state_next_s = ARMED;
                    end else begin
                        state_next_s = ARM_DELAY;
                    end
                end
                default: begin
                    state_next_s = ARMED;
                end
            endcase
        end

        // Alarm bookkeeping is meaningful only while sounding.
        if (state_next_s != SOUND_ALARM) begin
            restart_pend_next_s = 1'b0;
            alarm_run_next_s    = 1'b0;
        end else begin
            restart_pend_next_s = restart_pend_next_s;
            alarm_run_next_s    = alarm_run_next_s;
        end
    end

`ifdef STATUS_BLINK_EN
    // Blink phase: restarts at 0 on ARMED entry, toggles on each 1 Hz tick.
    always_comb begin
        blink_phase_next_s = 1'b0;
        if (state_next_s == ARMED) begin
            if (state_r != ARMED) begin
                blink_phase_next_s = 1'b0;
            end else if (one_hz_enable) begin
                blink_phase_next_s = ~blink_phase_r;
            end else begin
                blink_phase_next_s = blink_phase_r;
            end
        end else begin
            blink_phase_next_s = 1'b0;
        end
    end

    assign armed_status_s = blink_phase_next_s;
`else
    assign armed_status_s  = 1'b1;
    assign unused_one_hz_s = one_hz_enable;
`endif

    // Output decode from the upcoming state so outputs are registered with it.
    always_comb begin
        siren_next_s  = 1'b0;
        status_next_s = 1'b0;
        if (state_next_s == SOUND_ALARM) begin
            siren_next_s = 1'b1;
        end else begin
            siren_next_s = 1'b0;
        end
        case (state_next_s)
            ARMED:       status_next_s = armed_status_s;
            TRIGGERED:   status_next_s = 1'b1;
            SOUND_ALARM: status_next_s = 1'b1;
            default:     status_next_s = 1'b0;
        endcase
    end

    // Fuel pump latch: hidden+brake+ignition enables, ignition off disables.
    always_comb begin
        fuel_pump_next_s = fuel_pump_r;
        if (ignition && hidden && brake) begin
            fuel_pump_next_s = 1'b1;
        end else if (!ignition) begin
            fuel_pump_next_s = 1'b0;
        end else begin
            fuel_pump_next_s = fuel_pump_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ARMED;
            start_timer_r    <= 1'b0;
            interval_r       <= T_ARM_DELAY;
            siren_r          <= 1'b0;
            status_r         <= 1'b0;
            fuel_pump_r      <= 1'b0;
            reprogram_prev_r <= 1'b0;
            restart_pend_r   <= 1'b0;
            alarm_run_r      <= 1'b0;
`ifdef STATUS_BLINK_EN
            blink_phase_r    <= 1'b0;
`endif
        end else begin
            state_r          <= state_next_s;
            start_timer_r    <= start_timer_next_s;
            interval_r       <= interval_next_s;
            siren_r          <= siren_next_s;
            status_r         <= status_next_s;
            fuel_pump_r      <= fuel_pump_next_s;
            reprogram_prev_r <= reprogram;
            restart_pend_r   <= restart_pend_next_s;
            alarm_run_r      <= alarm_run_next_s;
`ifdef STATUS_BLINK_EN
            blink_phase_r    <= blink_phase_next_s;
`endif
        end
    end

    assign start_timer      = start_timer_r;
    assign interval         = interval_r;
    assign siren            = siren_r;
    assign status_indicator = status_r;
    assign fuel_pump        = fuel_pump_r;
    assign state_code       = state_r;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Self-checking bench for anti_theft_fsm. Each step applies one cycle of
// inputs, queues the hand-derived expected outputs, and compares them after
// the clock edge. Honours STATUS_BLINK_EN for the ARMED status expectations.
module tb_anti_theft_fsm;

`ifdef STATUS_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif
    // Status right after entering ARMED (blink phase 0, or steady on).
    localparam logic ARM0 = ~BLINK;

    logic       clk = 1'b0;
    logic       reset;
    logic       ignition, door_driver, door_passenger, hidden, brake;
    logic       reprogram, expired, one_hz_enable;
    logic       start_timer;
    logic [1:0] interval;
    logic       siren, status_indicator, fuel_pump;
    logic [2:0] state_code;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       stt;
        logic [1:0] iv;
        logic       sir;
        logic       sts;
        logic       fp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    anti_theft_fsm dut (
        .clk              (clk),
        .reset            (reset),
        .ignition         (ignition),
        .door_driver      (door_driver),
        .door_passenger   (door_passenger),
        .hidden           (hidden),
        .brake            (brake),
        .reprogram        (reprogram),
        .expired          (expired),
        .one_hz_enable    (one_hz_enable),
        .start_timer      (start_timer),
        .interval         (interval),
        .siren            (siren),
        .status_indicator (status_indicator),
        .fuel_pump        (fuel_pump),
        .state_code       (state_code)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Inputs as {ignition, driver, passenger, hidden, brake, reprogram, expired, one_hz}.
    task automatic set_in(input logic [7:0] v);
        ignition       = v[7];
        door_driver    = v[6];
        door_passenger = v[5];
        hidden         = v[4];
        brake          = v[3];
        reprogram      = v[2];
        expired        = v[1];
        one_hz_enable  = v[0];
    endtask

    // One clock with the current inputs; expected outputs after the edge.
    task automatic tick_exp(input string tag, input logic [2:0] st, input logic stt,
                            input logic [1:0] iv, input logic sir, input logic sts,
                            input logic fp);
        exp_t e;
        e.tag = tag; e.st = st; e.stt = stt; e.iv = iv;
        e.sir = sir; e.sts = sts; e.fp = fp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_value({e.tag, ".state"},    8'(state_code),       8'(e.st));
        check_value({e.tag, ".start"},    8'(start_timer),      8'(e.stt));
        check_value({e.tag, ".interval"}, 8'(interval),         8'(e.iv));
        check_value({e.tag, ".siren"},    8'(siren),            8'(e.sir));
        check_value({e.tag, ".status"},   8'(status_indicator), 8'(e.sts));
        check_value({e.tag, ".fuel"},     8'(fuel_pump),        8'(e.fp));
    endtask

    initial begin
        reset = 1'b1;
        set_in(8'b0000_0000);
        tick_exp("rst1", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick_exp("rst2", 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Driver entry -> countdown -> alarm.
        set_in(8'b0000_0000); tick_exp("a_idle", 3'd0, 1'b0, 2'd0, 1'b0, ARM0, 1'b0);
        set_in(8'b0100_0000); tick_exp("a_trig", 3'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            tick_exp("a_wait", 3'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        set_in(8'b0100_0010); tick_exp("a_exp",  3'd2, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);

        // Sounding: close starts, reopen (expiry ignored), close restarts, expiry re-arms.
        set_in(8'b0100_0000); tick_exp("b_open",  3'd2, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0000); tick_exp("b_close", 3'd2, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0000); tick_exp("b_run",   3'd2, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0010_0010); tick_exp("b_reopn", 3'd2, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0000); tick_exp("b_clos2", 3'd2, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0000); tick_exp("b_run2",  3'd2, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0010); tick_exp("b_exp",   3'd0, 1'b0, 2'd3, 1'b0, ARM0, 1'b0);

        // Arming path with passenger interruption and expiry during start pulse.
        set_in(8'b1000_0000); tick_exp("c_ign",   3'd3, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0000); tick_exp("c_igoff", 3'd4, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        set_in(8'b0100_0000); tick_exp("c_dopen", 3'd5, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0000); tick_exp("c_dcls",  3'd6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0010); tick_exp("c_expst", 3'd6, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0000); tick_exp("c_dly",   3'd6, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0010_0000); tick_exp("c_pass",  3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0010_0000); tick_exp("c_pass2", 3'd5, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0000); tick_exp("c_pcls",  3'd6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0000); tick_exp("c_dly2",  3'd6, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0000_0010); tick_exp("c_exp",   3'd0, 1'b0, 2'd0, 1'b0, ARM0, 1'b0);

        // Status LED in ARMED under 1 Hz ticks.
        set_in(8'b0000_0001); tick_exp("k_hz1",  3'd0, 1'b0, 2'd0, 1'b0, 1'b1,   1'b0);
        set_in(8'b0000_0000); tick_exp("k_idle", 3'd0, 1'b0, 2'd0, 1'b0, 1'b1,   1'b0);
        set_in(8'b0000_0001); tick_exp("k_hz2",  3'd0, 1'b0, 2'd0, 1'b0, ~BLINK, 1'b0);
        set_in(8'b0000_0001); tick_exp("k_hz3",  3'd0, 1'b0, 2'd0, 1'b0, 1'b1,   1'b0);
        set_in(8'b0000_0001); tick_exp("k_hz4",  3'd0, 1'b0, 2'd0, 1'b0, ~BLINK, 1'b0);

        // Fuel pump enable logic.
        set_in(8'b1001_1000); tick_exp("d_en",    3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        set_in(8'b1000_0000); tick_exp("d_hold",  3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        set_in(8'b0000_0000); tick_exp("d_off",   3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b0001_0000); tick_exp("d_hid",   3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b1001_0000); tick_exp("d_nobrk", 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        set_in(8'b1000_1000); tick_exp("d_nohid", 3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Priority cases: reprogram edge, ignition vs expiry.
        set_in(8'b0000_0100); tick_exp("e_rep",   3'd0, 1'b0, 2'd0, 1'b0, ARM0, 1'b0);
        set_in(8'b0000_0000); tick_exp("e_idle",  3'd0, 1'b0, 2'd0, 1'b0, ARM0, 1'b0);
        set_in(8'b0100_0100); tick_exp("e_repdr", 3'd0, 1'b0, 2'd0, 1'b0, ARM0, 1'b0);
        set_in(8'b0100_0100); tick_exp("e_trig",  3'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        set_in(8'b0000_0100); tick_exp("e_wait",  3'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        set_in(8'b1000_0010); tick_exp("e_igexp", 3'd3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
        set_in(8'b1000_0100); tick_exp("e_repig", 3'd0, 1'b0, 2'd1, 1'b0, ARM0, 1'b0);

        // Passenger trigger, driver-wins, alarm entry with doors closed.
        set_in(8'b0010_0100); tick_exp("f_pass",  3'd1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
        set_in(8'b0000_0000); tick_exp("f_wait",  3'd1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
        set_in(8'b0000_0100); tick_exp("f_rep",   3'd0, 1'b0, 2'd2, 1'b0, ARM0, 1'b0);
        set_in(8'b0110_0100); tick_exp("f_both",  3'd1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
        set_in(8'b0000_0100); tick_exp("f_wait2", 3'd1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
        set_in(8'b0000_0110); tick_exp("f_exp",   3'd2, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0100); tick_exp("f_entry", 3'd2, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0100); tick_exp("f_run",   3'd2, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
        set_in(8'b0000_0110); tick_exp("f_arm",   3'd0, 1'b0, 2'd3, 1'b0, ARM0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
